// File: rtl/capture_ctrl.sv
// Acquisition sequencer for the 512x8 scope sample RAM: circular pre-trigger capture, trigger, freeze, readout.
// Optional auto-trigger timeout is compiled in with `define CAPTURE_AUTO_TRIG_EN.
module capture_ctrl #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PRETRIG = 128,
    parameter int unsigned AUTO_TO = 2 ** 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              arm,
    input  logic              sample_en,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_slope,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_rdaddress,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_index,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              auto_trig
);
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam int unsigned POSTTRIG = DEPTH - PRETRIG;

    if (PRETRIG < 1 || PRETRIG > DEPTH - 2 || AUTO_TO < 1) begin : g_param_check
        $error("capture_ctrl: PRETRIG or AUTO_TO out of range");
    end

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
    state_t state, state_d;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] seg_cnt;
    logic [DATA_W-1:0] prev;
    logic              capturing;
    logic              start;
    logic              crossed;
    logic              timeout;
    logic              fire;
    logic              rd_pipe;

    always_comb begin
        state_d   = state;
        fire      = 1'b0;
        start     = arm && (state == IDLE || state == DONE);
        capturing = (state == PRE) || (state == ARMED) || (state == POST);
        crossed   = trig_slope ? (prev > trig_level && adc_data <= trig_level)
                               : (prev < trig_level && adc_data >= trig_level);
        case (state)
            IDLE, DONE: if (start) state_d = PRE;
            PRE:        if (sample_en && seg_cnt == ADDR_W'(PRETRIG - 1)) state_d = ARMED;
            ARMED: begin
                if (sample_en && (crossed || timeout)) begin
                    fire    = 1'b1;
                    state_d = POST;
                end
            end
            POST:       if (sample_en && seg_cnt == ADDR_W'(POSTTRIG - 1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // seg_cnt counts PRE samples, then POST samples (the trigger sample is number 1).
    // prev follows every captured strobe; PRE always captures at least one sample,
    // so ARMED never compares against data left over from an earlier capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr        <= '0;
            trig_addr     <= '0;
            seg_cnt       <= '0;
            prev          <= '0;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
            ram_rdaddress <= '0;
            rd_pipe       <= 1'b0;
            rd_valid      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            ram_wren <= sample_en && capturing;
            if (sample_en && capturing) begin
                ram_data      <= adc_data;
                ram_wraddress <= wr_ptr;
                wr_ptr        <= wr_ptr + ADDR_W'(1);
                prev          <= adc_data;
            end

            if (start) begin
                seg_cnt <= '0;
                busy    <= 1'b1;
                done    <= 1'b0;
            end else if (fire) begin
                seg_cnt   <= ADDR_W'(1);
                trig_addr <= wr_ptr;
            end else if (sample_en && (state == PRE || state == POST)) begin
                seg_cnt <= seg_cnt + ADDR_W'(1);
            end

            if (state == POST && state_d == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end

            rd_pipe  <= rd_req && (state == DONE);
            rd_valid <= rd_pipe;
            if (rd_req && state == DONE)
                ram_rdaddress <= trig_addr - ADDR_W'(PRETRIG) + rd_index;
        end
    end

    assign rd_data = ram_q;

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int unsigned TO_W = $clog2(AUTO_TO + 1);
    logic [TO_W-1:0] to_cnt;
    logic            auto_q;

    assign timeout   = (to_cnt == TO_W'(AUTO_TO - 1));
    assign auto_trig = auto_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            to_cnt <= '0;
            auto_q <= 1'b0;
        end else begin
            if (state != ARMED) to_cnt <= '0;
            else if (sample_en) to_cnt <= to_cnt + TO_W'(1);
            if (start)     auto_q <= 1'b0;
            else if (fire) auto_q <= ~crossed;
        end
    end
`else
    assign timeout   = 1'b0;
    assign auto_trig = 1'b0;
`endif

endmodule
